dm_responder: RTL and testbench
===============================

# dm_responder

Data-memory responder serving the CPU's load/store port with a request/stall/response handshake, replacing the zero-wait data memory. It samples one request per transaction and holds the core in stall for a configurable number of wait cycles. It commits writes or returns read data together with a one-cycle response strobe. It sits between the CPU's ALU-address/store-data outputs and the register-file writeback mux.

## Interface
- `ADDR_W`, 16: request address width.
- `DATA_W`, 16: data word width.
- `DEPTH`, 256: number of words stored; addresses `>= DEPTH` are out of range.
- `LATENCY`, 2: wait cycles between accept and response. Legal range 1..15.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_addr` input ADDR_W: word address, from ALU `dst`.
- `req_re` input 1: load request.
- `req_we` input 1: store request.
- `req_wdata` input DATA_W: store data.
- `stall` output 1: core must hold PC and pipeline state while high.
- `rsp_valid` output 1: one-cycle strobe; transaction complete this cycle.
- `rsp_rdata` output DATA_W: load data, valid when `rsp_valid` is high for a read.
- `rsp_err` output 1: high with `rsp_valid` when the transaction was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE.** `stall = req_re | req_we`, combinational. On a clock edge with either request bit high, latch addr/wdata/kind, load the wait counter with LATENCY-1, and go to WAIT. Otherwise stay in IDLE.
- **WAIT.** `stall = 1`. Request inputs are ignored; the latched copy is used. The counter decrements each cycle. When the counter reaches 0, the next edge goes to RESP and performs the access:
  - Write: array[addr] <= wdata.
  - Read: `rsp_rdata` <= array[addr].
- **RESP.** `stall = 0`, `rsp_valid = 1`, `rsp_err` per the latched error. The next edge always goes to IDLE. Request inputs present in RESP belong to the completing instruction and are ignored.
- **Error cases.**
  - Address out of range: no array write; `rsp_rdata` <= 0; `rsp_err` = 1.
  - `req_re` and `req_we` both high: treated as an error; no access, `rsp_rdata` <= 0, `rsp_err` = 1.
- **Held values.** `rsp_rdata` holds its value between responses. A write response leaves it unchanged.
- **Indexing.** The array is indexed by `req_addr[$clog2(DEPTH)-1:0]` after the range check.

## Timing
- Request presented in cycle 0 (IDLE). `stall` is high in cycles 0..LATENCY. `rsp_valid` is high in cycle LATENCY+1, with `stall` low in that cycle.
- Total cost per access: LATENCY+1 extra cycles relative to a zero-wait memory.
- Back-to-back accesses: the earliest next accept is the cycle after RESP. The state sequence is RESP, IDLE(accept), WAIT, and so on.
- Reset values: state IDLE, counter 0, `rsp_valid` 0, `rsp_err` 0, `rsp_rdata` 0. `stall` then follows the combinational IDLE rule.
- Reset asserted mid-transaction (WAIT or RESP): the transaction is abandoned with no array write and no response. The FSM returns to IDLE asynchronously. Array contents are not reset.
- The array has no reset and no initialization guarantee; the bench must write before reading.

## Structure
- Shared package `dm_pkg`:
  - State enum `dm_state_t` {IDLE, WAIT, RESP}.
  - Default constants `DM_LATENCY_DEF = 2`, `DM_DEPTH_DEF = 256`.
- Sub-module `dm_array`:
  - Synchronous write (`we`, `waddr`, `wdata`) and asynchronous read (`raddr`, `rdata`), DEPTH x DATA_W.
  - The FSM, counter, range check and output registers stay in `dm_responder`.

## Test plan
- **Reset:** `rst` = 1 with no request → `stall` 0, `rsp_valid` 0, `rsp_rdata` 0x0000. With `req_re` = 1 while in IDLE after reset → `stall` 1 combinationally.
- **Store then load, LATENCY = 2:** `req_we` = 1, addr 0x0010, wdata 0xBEEF → `stall` high for 3 cycles, `rsp_valid` pulse in cycle 3 with `rsp_err` 0. Then `req_re` at 0x0010 → `rsp_rdata` = 0xBEEF with `rsp_valid`, 3 stall cycles.
- **Out of range:** `req_we` at 0x0100 (DEPTH = 256) → `rsp_valid` = 1, `rsp_err` = 1, no write. A later read of 0x0000 returns its previously written value unchanged.
- **Both strobes high:** `req_re` = `req_we` = 1 at 0x0005 → `rsp_err` = 1, `rsp_rdata` = 0, address 0x0005 not modified.
- **Input change during WAIT:** issue a read at 0x0010, then change `req_addr` to 0x0020 during WAIT → returned data is from 0x0010.
- **Reset mid-WAIT and LATENCY = 1:** store 0x1234 to 0x0003 and assert `rst` in the first WAIT cycle → no `rsp_valid`; a later read of 0x0003 returns the old value. With LATENCY = 1, `stall` is high for 2 cycles and `rsp_valid` arrives in cycle 2.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and default constants for the data-memory responder.
package dm_pkg;

  // Responder FSM states; values are fixed so the debug state output is stable.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  localparam int DM_LATENCY_DEF = 2;
  localparam int DM_DEPTH_DEF   = 256;

endpackage

// File: rtl/dm_array.sv
// Word storage: synchronous write, asynchronous read, no reset.
module dm_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 16,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Commit a store on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store, stalls the core for
// LATENCY wait cycles, then completes with a one-cycle response strobe.
//
// Handshake: while idle, a high req_re or req_we is a request and stall
// rises in the same cycle; the request is captured on the next edge. Stall
// stays high through the wait cycles and drops in the response cycle, where
// rsp_valid pulses for exactly one cycle (with rsp_err on a rejected
// request). Request inputs are ignored from capture until the cycle after
// the response.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = DM_DEPTH_DEF,
  parameter int LATENCY = DM_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_RESP = RESP;

  // One extra bit so the limit is representable even when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      CNT_LOAD  = 4'(LATENCY - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [AW-1:0]     r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_is_rd;
  logic              r_is_wr;
  logic              r_err;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_req;
  logic              w_bad;
  logic              w_fire;
  logic              w_mem_we;
  logic              w_stall;
  logic [DATA_W-1:0] w_rdata;

  assign w_req    = req_re | req_we;
  // Rejected: out of range, or both strobes high (ambiguous kind).
  assign w_bad    = ({1'b0, req_addr} >= DEPTH_LIM) | (req_re & req_we);
  // Last wait cycle: the access happens on the edge that enters RESP.
  assign w_fire   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_mem_we = w_fire & r_is_wr & ~r_err;

  dm_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (r_addr),
    .wdata (r_wdata),
    .raddr (r_addr),
    .rdata (w_rdata)
  );

  // Stall: combinational on the request while idle, forced high while waiting.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:  w_stall = w_req;
      S_WAIT:  w_stall = 1'b1;
      default: w_stall = 1'b0;
    endcase
  end

  // FSM, wait counter, request capture and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_is_rd     <= 1'b0;
      r_is_wr     <= 1'b0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_LOAD;
            r_addr  <= req_addr[AW-1:0];
            r_wdata <= req_wdata;
            r_is_rd <= req_re;
            r_is_wr <= req_we;
            r_err   <= w_bad;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_err;
            if (r_err) begin
              r_rsp_rdata <= '0;
            end else if (r_is_rd) begin
              r_rsp_rdata <= w_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign stall     = w_stall;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed cases plus random traffic against a
// behavioural memory model, with a queue-based response scoreboard.
module tb_dm_responder;
  import dm_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;
  localparam int LAT    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (LATENCY = 2)
  logic [ADDR_W-1:0] a_addr;
  logic              a_re, a_we;
  logic [DATA_W-1:0] a_wdata;
  logic              a_stall, a_valid, a_err;
  logic [DATA_W-1:0] a_rdata;
  logic [1:0]        a_dbg;

  // Second instance (LATENCY = 1)
  logic [ADDR_W-1:0] b_addr;
  logic              b_re, b_we;
  logic [DATA_W-1:0] b_wdata;
  logic              b_stall, b_valid, b_err;
  logic [DATA_W-1:0] b_rdata;
  logic [1:0]        b_dbg;

  dm_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_addr(a_addr), .req_re(a_re), .req_we(a_we),
    .req_wdata(a_wdata), .stall(a_stall), .rsp_valid(a_valid),
    .rsp_rdata(a_rdata), .rsp_err(a_err), .dbg_state(a_dbg)
  );

  dm_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_addr(b_addr), .req_re(b_re), .req_we(b_we),
    .req_wdata(b_wdata), .stall(b_stall), .rsp_valid(b_valid),
    .rsp_rdata(b_rdata), .rsp_err(b_err), .dbg_state(b_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected response = {err, rdata}. The memory is a plain associative
  // array; last_rd tracks what the read-data output should currently hold.
  logic [DATA_W-1:0] mem_m [int];
  logic [DATA_W-1:0] last_rd = '0;
  logic [DATA_W:0]   exp_q [$];

  function automatic logic [DATA_W:0] model(input logic re, input logic we,
                                            input logic [ADDR_W-1:0] addr,
                                            input logic [DATA_W-1:0] wd);
    if ((re && we) || (int'(addr) >= DEPTH)) begin
      last_rd = '0;
      return {1'b1, 16'h0000};
    end
    if (we) begin
      mem_m[int'(addr)] = wd;
    end else begin
      last_rd = mem_m[int'(addr)];
    end
    return {1'b0, last_rd};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [DATA_W:0] e;
    if (rst === 1'b0 && a_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with no pending request at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", 32'(a_err), 32'(e[DATA_W]));
        check("rsp_rdata", 32'(a_rdata), 32'(e[DATA_W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit u, input logic re, input logic we,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    if (u) begin
      b_re = re; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_re = re; a_we = we; a_addr = addr; a_wdata = wd;
    end
  endtask

  // Presents a request in the idle cycle and holds the strobes while stalled
  // (as a core would). Returns the number of cycles stall was seen high and
  // the response outputs sampled in the cycle stall dropped.
  task automatic issue(input bit u, input logic re, input logic we,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                       input bit scramble, output int ns, output logic v,
                       output logic [DATA_W-1:0] rd, output logic e);
    @(negedge clk);
    drive(u, re, we, addr, wd);
    #1;
    ns = 0;
    while ((u ? b_stall : a_stall) && ns < 40) begin
      ns++;
      @(negedge clk);
      if (scramble) drive(u, re, we, 16'($urandom), 16'($urandom));
      #1;
    end
    v  = u ? b_valid : a_valid;
    rd = u ? b_rdata : a_rdata;
    e  = u ? b_err   : a_err;
    drive(u, 1'b0, 1'b0, addr, wd);
  endtask

  // Main-instance transaction: push the model's expectation, run it, check timing.
  task automatic txn(input logic re, input logic we, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] wd, input bit scramble);
    int ns;
    logic v, e;
    logic [DATA_W-1:0] rd;
    exp_q.push_back(model(re, we, addr, wd));
    issue(1'b0, re, we, addr, wd, scramble, ns, v, rd, e);
    check("stall_cycles", 32'(ns), 32'(LAT + 1));
    check("rsp_valid_at_stall_drop", 32'(v), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [ADDR_W-1:0] wr_addrs [$];

  initial begin
    int ns, r;
    logic v, e;
    logic [DATA_W-1:0] rd;
    logic [ADDR_W-1:0] ad;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check("reset_stall", 32'(a_stall), 32'd0);
    check("reset_rsp_valid", 32'(a_valid), 32'd0);
    check("reset_rsp_rdata", 32'(a_rdata), 32'h0);
    check("reset_state", 32'(a_dbg), 32'(IDLE));

    rst = 1'b0;
    @(negedge clk);
    a_re = 1'b1;
    #1 check("idle_comb_stall_on", 32'(a_stall), 32'd1);
    a_re = 1'b0;
    #1 check("idle_comb_stall_off", 32'(a_stall), 32'd0);

    // Store then load
    txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    txn(1'b0, 1'b1, 16'h0000, 16'h5A5A, 1'b0);
    txn(1'b0, 1'b1, 16'h0005, 16'h0505, 1'b0);
    // Out of range store, then the in-range word is untouched
    txn(1'b0, 1'b1, 16'h0100, 16'hDEAD, 1'b0);
    txn(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    // Both strobes: error, no access
    txn(1'b1, 1'b1, 16'h0005, 16'hFFFF, 1'b0);
    txn(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0);
    // Address changes while waiting must not matter
    txn(1'b0, 1'b1, 16'h0020, 16'h2020, 1'b0);
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
    // Write response leaves read data held
    txn(1'b0, 1'b1, 16'h0003, 16'h0333, 1'b0);

    // Reset in the first wait cycle abandons the store
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 16'h0003, 16'h1234);
    @(negedge clk);
    check("accepted_before_reset", 32'(a_dbg), 32'(WAIT));
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0003, 16'h1234);
    #1 check("reset_mid_wait_stall", 32'(a_stall), 32'd0);
    check("reset_mid_wait_state", 32'(a_dbg), 32'(IDLE));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_rsp_in_reset", 32'(a_valid), 32'd0);
    end
    rst = 1'b0;
    txn(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);

    // LATENCY = 1 instance
    issue(1'b1, 1'b0, 1'b1, 16'h0007, 16'h00AA, 1'b0, ns, v, rd, e);
    check("lat1_wr_stall_cycles", 32'(ns), 32'd2);
    check("lat1_wr_valid", 32'(v), 32'd1);
    check("lat1_wr_err", 32'(e), 32'd0);
    issue(1'b1, 1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, ns, v, rd, e);
    check("lat1_rd_stall_cycles", 32'(ns), 32'd2);
    check("lat1_rd_valid", 32'(v), 32'd1);
    check("lat1_rd_data", 32'(rd), 32'h00AA);
    @(negedge clk);
    check("lat1_valid_one_cycle", 32'(b_valid), 32'd0);

    // Random traffic
    for (int k = 0; k < 16; k++) wr_addrs.push_back(16'(k));
    for (int k = 0; k < 16; k++) void'(model(1'b0, 1'b1, 16'(k), 16'h0));
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(model(1'b0, 1'b1, 16'(k), 16'(k * 16'h0101)));
      issue(1'b0, 1'b0, 1'b1, 16'(k), 16'(k * 16'h0101), 1'b0, ns, v, rd, e);
      check("preload_stall_cycles", 32'(ns), 32'(LAT + 1));
    end
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        ad = 16'($urandom_range(0, DEPTH - 1));
        wr_addrs.push_back(ad);
        txn(1'b0, 1'b1, ad, 16'($urandom), 1'($urandom_range(0, 1)));
      end else if (r < 8) begin
        ad = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
        txn(1'b1, 1'b0, ad, 16'($urandom), 1'($urandom_range(0, 1)));
      end else if (r == 8) begin
        ad = 16'($urandom_range(DEPTH, 65535));
        if ($urandom_range(0, 1) == 1) txn(1'b1, 1'b0, ad, 16'($urandom), 1'b0);
        else txn(1'b0, 1'b1, ad, 16'($urandom), 1'b0);
      end else begin
        txn(1'b1, 1'b1, 16'($urandom_range(0, DEPTH - 1)), 16'($urandom), 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
